// File: rtl/dvbc_pkg.sv
// Shared DVB-C constants: QAM mode encodings and the mode-to-bits-per-symbol lookup.
// The QAM mapper uses the same definitions.
package dvbc_pkg;

    localparam int QAM_MODE_W = 3;
    localparam int SYM_W      = 8;

    typedef enum logic [QAM_MODE_W-1:0] {
        QAM16  = 3'd0,
        QAM32  = 3'd1,
        QAM64  = 3'd2,
        QAM128 = 3'd3,
        QAM256 = 3'd4
    } qam_mode_e;

    // Codes 5..7 are not defined modes; they fall back to 256-QAM (8 bits).
    function automatic logic [3:0] qam_bits(input logic [QAM_MODE_W-1:0] mode);
        case (mode)
            QAM16:   qam_bits = 4'd4;
            QAM32:   qam_bits = 4'd5;
            QAM64:   qam_bits = 4'd6;
            QAM128:  qam_bits = 4'd7;
            default: qam_bits = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dvbc_diff_enc.sv
// Differential encoder for the two symbol MSBs (J.83 Annex A rotation-invariant coding).
// Purely combinational so reference models can instantiate it directly.
module dvbc_diff_enc (
    input  logic i_a,
    input  logic i_b,
    input  logic i_i_prev,
    input  logic i_q_prev,
    output logic o_i_k,
    output logic o_q_k
);

    logic w_x;

    // When A and B differ, the previous I/Q references swap.
    assign w_x   = i_a ^ i_b;
    assign o_i_k = i_a ^ (w_x ? i_q_prev : i_i_prev);
    assign o_q_k = i_b ^ (w_x ? i_i_prev : i_q_prev);

endmodule

// File: rtl/dvbc_byte_to_symbol.sv
// Byte-to-m-tuple converter for DVB-C: packs bytes into a left-aligned bit buffer and
// emits differentially encoded m-bit symbols through a one-entry output register.
module dvbc_byte_to_symbol
    import dvbc_pkg::*;
#(
    parameter int BUF_W  = 15,
    parameter int MODE_W = QAM_MODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] qam_mode_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [SYM_W-1:0]  sym_o,
    output logic              sym_valid_o,
    input  logic              sym_ready_i
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // byte_ready_o depends only on registered state; a held symbol stays stable until taken.

    logic [BUF_W-1:0]  r_buf;
    logic [3:0]        r_cnt;
    logic [MODE_W-1:0] r_mode;
    logic [SYM_W-1:0]  r_sym;
    logic              r_sym_valid;
    logic              r_i_prev;
    logic              r_q_prev;

    logic [3:0]        w_m;
    logic              w_accept;
    logic              w_pop;
    logic [SYM_W-1:0]  w_raw;
    logic [2:0]        w_msb_idx;
    logic [2:0]        w_lsb_idx;
    logic              w_i_k;
    logic              w_q_k;
    logic [SYM_W-1:0]  w_sym_enc;
    logic [3:0]        w_cnt_after_pop;
    logic [BUF_W-1:0]  w_buf_after_pop;
    logic [BUF_W-1:0]  w_byte_aligned;
    logic [BUF_W-1:0]  w_buf_next;
    logic [3:0]        w_cnt_next;

    assign w_m          = qam_bits(r_mode);
    assign byte_ready_o = (r_cnt <= 4'd7);
    assign w_accept     = byte_valid_i & byte_ready_o;
    assign w_pop        = (r_cnt >= w_m) & (~r_sym_valid | sym_ready_i);

    // The oldest m bits sit at the top of the buffer; right-align them.
    assign w_raw     = r_buf[BUF_W-1 -: SYM_W] >> (4'd8 - w_m);
    assign w_msb_idx = 3'(w_m - 4'd1);
    assign w_lsb_idx = 3'(w_m - 4'd2);

    dvbc_diff_enc u_diff_enc (
        .i_a      (w_raw[w_msb_idx]),
        .i_b      (w_raw[w_lsb_idx]),
        .i_i_prev (r_i_prev),
        .i_q_prev (r_q_prev),
        .o_i_k    (w_i_k),
        .o_q_k    (w_q_k)
    );

    always_comb begin
        w_sym_enc            = w_raw;
        w_sym_enc[w_msb_idx] = w_i_k;
        w_sym_enc[w_lsb_idx] = w_q_k;
    end

    // Pop first, then append the new byte directly behind whatever bits remain.
    assign w_cnt_after_pop = w_pop ? (r_cnt - w_m) : r_cnt;
    assign w_buf_after_pop = w_pop ? (r_buf << w_m) : r_buf;
    assign w_byte_aligned  = {byte_i, {(BUF_W-8){1'b0}}} >> w_cnt_after_pop;
    assign w_buf_next      = w_accept ? (w_buf_after_pop | w_byte_aligned) : w_buf_after_pop;
    assign w_cnt_next      = w_cnt_after_pop + (w_accept ? 4'd8 : 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_mode      <= MODE_W'(QAM256);
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_i_prev    <= 1'b0;
            r_q_prev    <= 1'b0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
            // Mode only changes on a symbol boundary, i.e. when the buffer is empty.
            if (w_accept && (r_cnt == 4'd0)) begin
                r_mode <= qam_mode_i;
            end
            if (w_pop) begin
                r_sym       <= w_sym_enc;
                r_sym_valid <= 1'b1;
                r_i_prev    <= w_i_k;
                r_q_prev    <= w_q_k;
            end else if (sym_ready_i) begin
                r_sym_valid <= 1'b0;
            end
        end
    end

    assign sym_o       = r_sym;
    assign sym_valid_o = r_sym_valid;

endmodule
